// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: bus address/strobe and processor interrupt handshake.
// The controller connects through the slave modport, the CPU side through master.
// BUS_DATA is a resolved tristate net and stays a plain inout port on the controller.
interface interrupt_controller_if;
   logic [7:0] BUS_ADDR;
   logic       BUS_WE;
   logic       CPU_INTERRUPT;
   logic       CPU_INTERRUPT_ACK;
   logic [1:0] CPU_INTERRUPT_ID;

   modport master (
      output BUS_ADDR, BUS_WE, CPU_INTERRUPT_ACK,
      input  CPU_INTERRUPT, CPU_INTERRUPT_ID
   );

   modport slave (
      input  BUS_ADDR, BUS_WE, CPU_INTERRUPT_ACK,
      output CPU_INTERRUPT, CPU_INTERRUPT_ID
   );
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches rising edges on four peripheral raise lines,
// dispatches one source at a time to the CPU and returns a one-cycle IRQ_ACK.
// Register window of four bytes at IntcBaseAddr on the shared 8-bit bus.
// Build macro INTC_ROTATE_PRIORITY_EN selects round-robin arbitration;
// without it arbitration is fixed priority with source 0 highest.
module interrupt_controller #(
   parameter logic [7:0] IntcBaseAddr = 8'hE0,
   parameter logic [3:0] InitialMask  = 4'hF
) (
   input  logic                  CLK,
   input  logic                  RESET,
   inout  wire  [7:0]            BUS_DATA,
   interrupt_controller_if.slave bus,
   input  logic [3:0]            IRQ_RAISE,
   output logic [3:0]            IRQ_ACK
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_ACK     = 2'd2;
   localparam logic [1:0] ST_HOLDOFF = 2'd3;

   logic [1:0] state_q, state_d;
   logic [1:0] id_q, id_d;
   logic       cpu_int_q, cpu_int_d;
   logic [3:0] irq_ack_q, irq_ack_d;
   logic [3:0] raise_prev_q;
   logic [3:0] pending_q, pending_d;
   logic [3:0] mask_q, mask_d;
   logic [3:0] eligible_q;
   logic       rd_en_q, rd_en_d;
   logic [7:0] rd_data_q, rd_data_d;

   logic [7:0] offset;
   logic       in_window;
   logic       wr_mask;
   logic       wr_clear;
   logic       busy;
   logic [1:0] search_base;
   logic [1:0] cand;
   logic       win_valid;
   logic [1:0] win_id;

   // Offset arithmetic keeps the decode correct for any base, aligned or not.
   assign offset    = bus.BUS_ADDR - IntcBaseAddr;
   assign in_window = (offset[7:2] == 6'd0);
   assign wr_mask   = in_window && bus.BUS_WE && (offset[1:0] == 2'd1);
   assign wr_clear  = in_window && bus.BUS_WE && (offset[1:0] == 2'd2);
   assign busy      = (state_q != ST_IDLE);

`ifdef INTC_ROTATE_PRIORITY_EN
   logic [1:0] ptr_q, ptr_d;

   // Rotation pointer moves just past the source being acknowledged.
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ST_ACK) ptr_d = id_q + 2'd1;
   end

   // Rotation pointer register.
   always_ff @(posedge CLK) begin
      if (RESET) ptr_q <= 2'd0;
      else       ptr_q <= ptr_d;
   end

   assign search_base = ptr_q;
`else
   assign search_base = 2'd0;
`endif

   // Arbiter: first eligible source at or after search_base, wrapping mod 4.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
      win_valid = 1'b0;
      win_id    = 2'd0;
      cand      = 2'd0;
      // Walk from the farthest candidate down so the nearest one is written last.
      for (int k = 3; k >= 0; k--) begin
         cand = search_base + 2'(k);
         if (eligible_q[cand]) begin
            win_valid = 1'b1;
            win_id    = cand;
         end
      end
   end

   // Pending: write-1-to-clear and dispatch clear, then a new edge overrides both.
   always_comb begin
      pending_d = pending_q;
      if (wr_clear) pending_d = pending_d & ~BUS_DATA[3:0];
      if (state_q == ST_ACK) pending_d[id_q] = 1'b0;
      pending_d = pending_d | (IRQ_RAISE & ~raise_prev_q);
   end

   // Mask register write.
   always_comb begin
      mask_d = mask_q;
      if (wr_mask) mask_d = BUS_DATA[3:0];
   end

   // Read path: capture the addressed register now, drive the bus next cycle.
   always_comb begin
      rd_en_d   = in_window && !bus.BUS_WE;
      rd_data_d = 8'h00;
      case (offset[1:0])
         2'd0:    rd_data_d = {4'b0000, pending_q};
         2'd1:    rd_data_d = {4'b0000, mask_q};
         2'd3:    rd_data_d = {busy, 5'b00000, id_q};
         default: rd_data_d = 8'h00;
      endcase
   end

   // Dispatch FSM; the ID is frozen from ASSERT entry until back in IDLE.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      cpu_int_d = 1'b0;
      irq_ack_d = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d   = ST_ASSERT;
               id_d      = win_id;
               cpu_int_d = 1'b1;
            end
         end
         ST_ASSERT: begin
            if (bus.CPU_INTERRUPT_ACK) begin
               state_d         = ST_ACK;
               irq_ack_d[id_q] = 1'b1;
            end else begin
               cpu_int_d = 1'b1;
            end
         end
         ST_ACK:  state_d = ST_HOLDOFF;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values regardless of statement order.
      if (RESET) begin
         state_q      <= ST_IDLE;
         id_q         <= 2'd0;
         cpu_int_q    <= 1'b0;
         irq_ack_q    <= 4'b0000;
         raise_prev_q <= 4'b0000;
         pending_q    <= 4'b0000;
         mask_q       <= InitialMask;
         eligible_q   <= 4'b0000;
         rd_en_q      <= 1'b0;
         rd_data_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         cpu_int_q    <= cpu_int_d;
         irq_ack_q    <= irq_ack_d;
         raise_prev_q <= IRQ_RAISE;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         eligible_q   <= pending_q & mask_q;
         rd_en_q      <= rd_en_d;
         rd_data_q    <= rd_data_d;
      end
   end

   assign bus.CPU_INTERRUPT    = cpu_int_q;
   assign bus.CPU_INTERRUPT_ID = id_q;
   assign IRQ_ACK              = irq_ack_q;
   assign BUS_DATA             = rd_en_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: register-map vector table, directed multi-cycle
// sequences and a randomized dispatch-order test against a priority model.
module tb_interrupt_controller;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   interrupt_controller_if bus_if ();

   wire  [7:0] bus_data;
   logic       tb_drv;
   logic [7:0] tb_wdata;
   assign bus_data = tb_drv ? tb_wdata : 8'hzz;
   // A released bus reads as 8'hFF, a value no register of the controller can return.
   pullup (bus_data);

   logic [3:0] irq_raise;
   logic [3:0] irq_ack;

   interrupt_controller dut (
      .CLK       (clk),
      .RESET     (rst),
      .BUS_DATA  (bus_data),
      .bus       (bus_if),
      .IRQ_RAISE (irq_raise),
      .IRQ_ACK   (irq_ack)
   );

   int checks = 0;
   int errors = 0;
   int ack_pulses = 0;

   always @(negedge clk) if (irq_ack != 4'b0000) ack_pulses <= ack_pulses + 1;

   typedef struct {
      bit         we;
      logic [7:0] addr;
      logic [7:0] data;   // write data, or expected read data
      string      name;
   } bus_vec_t;

   localparam int NV = 11;
   bus_vec_t vecs[NV];

   function automatic bus_vec_t mkv(bit we, logic [7:0] a, logic [7:0] dt, string n);
      bus_vec_t v;
      v.we = we; v.addr = a; v.data = dt; v.name = n;
      return v;
   endfunction

   function automatic logic [31:0] onehot(int i);
      return 32'(1) << i;
   endfunction

   // First eligible source scanning upward from ptr, wrapping mod 4.
   function automatic int model_pick(logic [3:0] elig, int ptr);
      for (int k = 0; k < 4; k++) begin
         if (elig[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] dt);
      bus_if.BUS_ADDR = a;
      bus_if.BUS_WE   = 1'b1;
      tb_wdata        = dt;
      tb_drv          = 1'b1;
      tick();
      bus_if.BUS_WE   = 1'b0;
      tb_drv          = 1'b0;
      bus_if.BUS_ADDR = 8'h00;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] dt);
      bus_if.BUS_ADDR = a;
      bus_if.BUS_WE   = 1'b0;
      tick();
      dt = bus_data;
      bus_if.BUS_ADDR = 8'h00;
      tick();
   endtask

   task automatic wait_irq(input int budget);
      int w;
      w = 0;
      while (!bus_if.CPU_INTERRUPT && w < budget) begin
         tick();
         w++;
      end
   endtask

   task automatic serve(input int exp_id, input string tag);
      wait_irq(12);
      check({tag, " irq"}, 32'(bus_if.CPU_INTERRUPT), 32'(1));
      check({tag, " id"}, 32'(bus_if.CPU_INTERRUPT_ID), 32'(exp_id));
      bus_if.CPU_INTERRUPT_ACK = 1'b1;
      tick();
      bus_if.CPU_INTERRUPT_ACK = 1'b0;
      check({tag, " irq_ack"}, 32'(irq_ack), onehot(exp_id));
      tick();
      check({tag, " ack width"}, 32'(irq_ack), 32'(0));
   endtask

   logic [7:0] d;
   logic [3:0] m_mask, m_pend, pat;
   int         first_id, second_id, exp_id, model_ptr, pulses_before;
   bit         abort;

   initial begin
      vecs[0]  = mkv(1'b0, 8'hE1, 8'h0F, "mask reset value");
      vecs[1]  = mkv(1'b1, 8'hE1, 8'h05, "");
      vecs[2]  = mkv(1'b0, 8'hE1, 8'h05, "mask readback");
      vecs[3]  = mkv(1'b1, 8'hE0, 8'h0F, "");
      vecs[4]  = mkv(1'b0, 8'hE0, 8'h00, "pending ignores write");
      vecs[5]  = mkv(1'b1, 8'hE3, 8'hFF, "");
      vecs[6]  = mkv(1'b0, 8'hE3, 8'h00, "status idle");
      vecs[7]  = mkv(1'b0, 8'hE4, 8'hFF, "released above window");
      vecs[8]  = mkv(1'b0, 8'hDF, 8'hFF, "released below window");
      vecs[9]  = mkv(1'b1, 8'hE1, 8'h0F, "");
      vecs[10] = mkv(1'b0, 8'hE1, 8'h0F, "mask restored");

      tb_drv = 1'b0; tb_wdata = 8'h00;
      bus_if.BUS_ADDR = 8'h00; bus_if.BUS_WE = 1'b0; bus_if.CPU_INTERRUPT_ACK = 1'b0;
      irq_raise = 4'b0000;
      abort = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;

      check("reset cpu_int", 32'(bus_if.CPU_INTERRUPT), 32'(0));
      check("reset id", 32'(bus_if.CPU_INTERRUPT_ID), 32'(0));
      check("reset irq_ack", 32'(irq_ack), 32'(0));
      check("reset bus released", 32'(bus_data), 32'(8'hFF));

      // Register map vectors.
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].data);
         else begin
            bus_read(vecs[i].addr, d);
            check(vecs[i].name, 32'(d), 32'(vecs[i].data));
         end
      end

      // Single held source: CPU_INTERRUPT three cycles after the raise, one ACK, no re-trigger.
      irq_raise = 4'b0010;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("single latency c%0d", k), 32'(bus_if.CPU_INTERRUPT), 32'(k == 3));
      end
      check("single id", 32'(bus_if.CPU_INTERRUPT_ID), 32'(1));
      repeat (3) tick();
      check("single held", 32'(bus_if.CPU_INTERRUPT), 32'(1));
      bus_if.CPU_INTERRUPT_ACK = 1'b1;
      tick();
      bus_if.CPU_INTERRUPT_ACK = 1'b0;
      check("single irq_ack", 32'(irq_ack), 32'(4'b0010));
      check("single cpu drop", 32'(bus_if.CPU_INTERRUPT), 32'(0));
      tick();
      check("single ack width", 32'(irq_ack), 32'(0));
      repeat (6) tick();
      check("single no retrigger", 32'(bus_if.CPU_INTERRUPT), 32'(0));
      bus_read(8'hE0, d);
      check("single pending clear", 32'(d), 32'(0));
      irq_raise = 4'b0000;
      repeat (2) tick();

      // Service source 0 alone, then raise sources 0 and 3 together.
      irq_raise = 4'b0001;
      serve(0, "prior0");
      irq_raise = 4'b0000;
      repeat (4) tick();
`ifdef INTC_ROTATE_PRIORITY_EN
      first_id = 3; second_id = 0;
`else
      first_id = 0; second_id = 3;
`endif
      irq_raise = 4'b1001;
      repeat (3) tick();
      check("simul first irq", 32'(bus_if.CPU_INTERRUPT), 32'(1));
      check("simul first id", 32'(bus_if.CPU_INTERRUPT_ID), 32'(first_id));
      bus_if.CPU_INTERRUPT_ACK = 1'b1;
      tick();
      bus_if.CPU_INTERRUPT_ACK = 1'b0;
      check("simul first ack", 32'(irq_ack), onehot(first_id));
      tick();
      check("simul gap m+2", 32'(bus_if.CPU_INTERRUPT), 32'(0));
      tick();
      check("simul gap m+3", 32'(bus_if.CPU_INTERRUPT), 32'(0));
      tick();
      check("simul second irq", 32'(bus_if.CPU_INTERRUPT), 32'(1));
      check("simul second id", 32'(bus_if.CPU_INTERRUPT_ID), 32'(second_id));
      bus_if.CPU_INTERRUPT_ACK = 1'b1;
      tick();
      bus_if.CPU_INTERRUPT_ACK = 1'b0;
      check("simul second ack", 32'(irq_ack), onehot(second_id));
      irq_raise = 4'b0000;
      repeat (3) tick();

      // Masked source stays pending; enabling it dispatches two cycles after the write.
      bus_write(8'hE1, 8'h0E);
      irq_raise = 4'b0001;
      repeat (5) tick();
      check("masked no irq", 32'(bus_if.CPU_INTERRUPT), 32'(0));
      bus_read(8'hE0, d);
      check("masked pending", 32'(d), 32'(8'h01));
      bus_write(8'hE1, 8'h0F);
      check("unmask +0", 32'(bus_if.CPU_INTERRUPT), 32'(0));
      tick();
      check("unmask +1", 32'(bus_if.CPU_INTERRUPT), 32'(0));
      tick();
      check("unmask +2", 32'(bus_if.CPU_INTERRUPT), 32'(1));
      bus_if.CPU_INTERRUPT_ACK = 1'b1;
      tick();
      bus_if.CPU_INTERRUPT_ACK = 1'b0;
      check("unmask ack", 32'(irq_ack), 32'(4'b0001));
      irq_raise = 4'b0000;
      repeat (3) tick();

      // Write-1-to-clear, then a clear racing a new edge on the same source.
      bus_write(8'hE1, 8'h0B);
      irq_raise = 4'b0100;
      repeat (2) tick();
      irq_raise = 4'b0000;
      repeat (2) tick();
      bus_read(8'hE0, d);
      check("w1c before", 32'(d), 32'(8'h04));
      bus_write(8'hE2, 8'h04);
      bus_read(8'hE0, d);
      check("w1c cleared", 32'(d), 32'(8'h00));
      irq_raise = 4'b0100;
      bus_write(8'hE2, 8'h04);
      bus_read(8'hE0, d);
      check("clear race set wins", 32'(d), 32'(8'h04));
      irq_raise = 4'b0000;
      bus_write(8'hE2, 8'h0F);
      bus_write(8'hE1, 8'h0F);
      repeat (2) tick();

      // Status readback during ASSERT, then mask the in-flight source.
      irq_raise = 4'b0100;
      wait_irq(8);
      check("rb irq", 32'(bus_if.CPU_INTERRUPT), 32'(1));
      bus_read(8'hE3, d);
      check("rb status", 32'(d), 32'(8'h82));
      bus_read(8'hE5, d);
      check("rb released", 32'(d), 32'(8'hFF));
      bus_write(8'hE1, 8'h0B);
      check("rb masked still asserted", 32'(bus_if.CPU_INTERRUPT), 32'(1));
      bus_if.CPU_INTERRUPT_ACK = 1'b1;
      tick();
      bus_if.CPU_INTERRUPT_ACK = 1'b0;
      check("rb masked ack", 32'(irq_ack), 32'(4'b0100));
      irq_raise = 4'b0000;
      bus_write(8'hE1, 8'h07);
      repeat (3) tick();

      // Reset while in ASSERT: everything idles, mask restored, no ACK pulse.
      irq_raise = 4'b0100;
      wait_irq(8);
      check("rst-assert irq", 32'(bus_if.CPU_INTERRUPT), 32'(1));
      pulses_before = ack_pulses;
      rst = 1'b1;
      irq_raise = 4'b0000;
      tick();
      rst = 1'b0;
      check("rst-assert cpu low", 32'(bus_if.CPU_INTERRUPT), 32'(0));
      check("rst-assert id", 32'(bus_if.CPU_INTERRUPT_ID), 32'(0));
      bus_if.CPU_INTERRUPT_ACK = 1'b1;
      tick();
      bus_if.CPU_INTERRUPT_ACK = 1'b0;
      bus_read(8'hE0, d);
      check("rst-assert pending", 32'(d), 32'(0));
      bus_read(8'hE1, d);
      check("rst-assert mask", 32'(d), 32'(8'h0F));
      repeat (3) tick();
      check("rst-assert no ack pulse", 32'(ack_pulses), 32'(pulses_before));
      check("rst-assert idle ack ignored", 32'(bus_if.CPU_INTERRUPT), 32'(0));

      // Randomized: service order from a priority model over random raise sets and masks.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_ptr = 0;
      for (int it = 0; it < 40 && !abort; it++) begin
         m_mask = 4'($urandom_range(0, 15));
         pat    = 4'($urandom_range(1, 15));
         bus_write(8'hE1, {4'h0, m_mask});
         irq_raise = pat;
         m_pend = pat;
         while (((m_pend & m_mask) != 4'b0000) && !abort) begin
            exp_id = model_pick(m_pend & m_mask, model_ptr);
            wait_irq(12);
            check("rnd irq", 32'(bus_if.CPU_INTERRUPT), 32'(1));
            if (!bus_if.CPU_INTERRUPT) abort = 1'b1;
            else begin
               check("rnd id", 32'(bus_if.CPU_INTERRUPT_ID), 32'(exp_id));
               repeat ($urandom_range(0, 3)) tick();
               bus_if.CPU_INTERRUPT_ACK = 1'b1;
               tick();
               bus_if.CPU_INTERRUPT_ACK = 1'b0;
               check("rnd irq_ack", 32'(irq_ack), onehot(exp_id));
               m_pend[exp_id] = 1'b0;
`ifdef INTC_ROTATE_PRIORITY_EN
               model_ptr = (exp_id + 1) % 4;
`endif
            end
         end
         repeat (4) tick();
         check("rnd quiet", 32'(bus_if.CPU_INTERRUPT), 32'(0));
         bus_read(8'hE0, d);
         check("rnd leftover pending", 32'(d), 32'(m_pend));
         bus_write(8'hE2, 8'h0F);
         irq_raise = 4'b0000;
         repeat (2) tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
